// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - multi-cycle big-endian byte-addressed data memory with req/ready handshake
// Faults (range, strobe, alignment) are resolved at acceptance and answered with the normal latency.
module data_mem_ctrl #(
    parameter int DEPTH_BYTES   = 1024,
    parameter int WAIT_STATES   = 1,
    parameter int MISALIGN_TRAP = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  StrobeM,
    input  logic [31:0] Address,
    input  logic [31:0] WriteDataM,
    output logic        ReadyM,
    output logic [31:0] ReadDataM,
    output logic        FaultM,
    output logic        BusyM
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]    wait_cnt;
    logic          we_q;
    logic [2:0]    strobe_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          fault_q;

    logic          accept;
    logic          out_of_range;
    logic          bad_strobe;
    logic          misaligned;
    logic          fault_d;

    logic [7:0]    mem [DEPTH_BYTES];
    logic [AW-1:0] idx [4];
    logic [7:0]    rd_byte [4];
    logic          sign_ext;
    logic [31:0]   load_data;
    logic          do_store;

    assign accept = (state == S_IDLE) && ReqM;
    assign BusyM  = (state != S_IDLE);

    assign out_of_range = (Address >= 32'(DEPTH_BYTES));
    assign bad_strobe   = (StrobeM == 3'b011) || (StrobeM == 3'b110) || (StrobeM == 3'b111);
    assign misaligned   = (MISALIGN_TRAP != 0) &&
                          (((StrobeM[1:0] == 2'b01) && Address[0]) ||
                           ((StrobeM[1:0] == 2'b10) && (Address[1:0] != 2'b00)));
    assign fault_d      = out_of_range || bad_strobe || misaligned;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ReqM) begin
                    state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Byte i of a multi-byte access sits at (A + i) mod DEPTH_BYTES; the index width gives the wrap.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            idx[i]     = addr_q + AW'(i);
            rd_byte[i] = mem[idx[i]];
        end
    end

    assign sign_ext = ~strobe_q[2] & rd_byte[0][7];

    always_comb begin
        load_data = 32'd0;
        case (strobe_q[1:0])
            2'b00:   load_data = {{24{sign_ext}}, rd_byte[0]};
            2'b01:   load_data = {{16{sign_ext}}, rd_byte[0], rd_byte[1]};
            default: load_data = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wait_cnt  <= 4'd0;
            ReadyM    <= 1'b0;
            FaultM    <= 1'b0;
            ReadDataM <= 32'd0;
            we_q      <= 1'b0;
            strobe_q  <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            ReadyM   <= 1'b0;
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 4'd1 : 4'd0;
            if (accept) begin
                we_q     <= MemWriteM;
                strobe_q <= StrobeM;
                addr_q   <= Address[AW-1:0];
                wdata_q  <= WriteDataM;
                fault_q  <= fault_d;
            end
            if (state == S_ACCESS) begin
                ReadyM    <= 1'b1;
                FaultM    <= fault_q;
                ReadDataM <= (fault_q || we_q) ? 32'd0 : load_data;
            end
        end
    end

    // Gated by RST so a store caught by reset in its ACCESS cycle never lands.
    assign do_store = RST && (state == S_ACCESS) && we_q && !fault_q;

    always_ff @(posedge CLK) begin
        if (do_store) begin
            case (strobe_q[1:0])
                2'b00: mem[idx[0]] <= wdata_q[7:0];
                2'b01: begin
                    mem[idx[0]] <= wdata_q[15:8];
                    mem[idx[1]] <= wdata_q[7:0];
                end
                default: begin
                    mem[idx[0]] <= wdata_q[31:24];
                    mem[idx[1]] <= wdata_q[23:16];
                    mem[idx[2]] <= wdata_q[15:8];
                    mem[idx[3]] <= wdata_q[7:0];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl
// Instance 0: WAIT_STATES=1, trap on misalign. Instance 1: WAIT_STATES=0, bytewise wrap.
module tb_data_mem_ctrl;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        req  [2];
    logic        we   [2];
    logic [2:0]  strb [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic        rdy  [2];
    logic [31:0] rd   [2];
    logic        flt  [2];
    logic        busy [2];

    int vectors;
    int miscompares;

    bit [7:0] mmem [2][DEPTH];

    data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(1), .MISALIGN_TRAP(1)) u_d0 (
        .CLK(clk), .RST(rst), .ReqM(req[0]), .MemWriteM(we[0]), .StrobeM(strb[0]),
        .Address(addr[0]), .WriteDataM(wd[0]), .ReadyM(rdy[0]), .ReadDataM(rd[0]),
        .FaultM(flt[0]), .BusyM(busy[0])
    );

    data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(0), .MISALIGN_TRAP(0)) u_d1 (
        .CLK(clk), .RST(rst), .ReqM(req[1]), .MemWriteM(we[1]), .StrobeM(strb[1]),
        .Address(addr[1]), .WriteDataM(wd[1]), .ReadyM(rdy[1]), .ReadDataM(rd[1]),
        .FaultM(flt[1]), .BusyM(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        w;
        bit [2:0]  s;
        bit [31:0] a;
        bit [31:0] wdat;
        bit        f;
        bit [31:0] rdat;
    } vec_t;

    vec_t tab [22];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Reference: byte list in address order, big-endian value, sign by arithmetic.
    function automatic void model_step(input int d, input bit w, input bit [2:0] s,
                                       input bit [31:0] a, input bit [31:0] wdat,
                                       output bit f, output bit [31:0] rdat);
        int n;
        longint v;
        longint unsigned au;
        au = longint'(a);
        n = (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
        f = 1'b0;
        rdat = 32'd0;
        if (au >= DEPTH) f = 1'b1;
        if (s == 3'd3 || s == 3'd6 || s == 3'd7) f = 1'b1;
        if (d == 0 && (au % longint'(n)) != 0) f = 1'b1;
        if (!f) begin
            if (w) begin
                for (int i = 0; i < n; i++)
                    mmem[d][int'((au + longint'(i)) % DEPTH)] = 8'(wdat >> (8 * (n - 1 - i)));
            end else begin
                v = 0;
                for (int i = 0; i < n; i++)
                    v = v * 256 + longint'(mmem[d][int'((au + longint'(i)) % DEPTH)]);
                if (!s[2] && v >= (longint'(1) << (8 * n - 1)))
                    v = v - (longint'(1) << (8 * n));
                rdat = 32'(v);
            end
        end
    endfunction

    task automatic do_acc(input int d, input bit w, input bit [2:0] s, input bit [31:0] a,
                          input bit [31:0] wdat, output bit [31:0] got_rd, output bit got_f,
                          output bit [31:0] exp_rd, output bit exp_f);
        int n;
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; strb[d] = s; addr[d] = a; wd[d] = wdat;
        @(posedge clk); #1;
        chk($sformatf("d%0d_busy_after_accept", d), busy[d], 1'b1);
        chk($sformatf("d%0d_ready_pulse_ended", d), rdy[d], 1'b0);
        req[d] = 1'b0; we[d] = ~w; strb[d] = 3'($urandom); addr[d] = $urandom; wd[d] = $urandom;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rdy[d] && n < 40);
        chk($sformatf("d%0d_latency_edges", d), n, (d == 0) ? 2 : 1);
        chk($sformatf("d%0d_idle_at_ready", d), busy[d], 1'b0);
        got_rd = rd[d];
        got_f  = flt[d];
        model_step(d, w, s, a, wdat, exp_f, exp_rd);
    endtask

    initial begin
        bit [31:0] grd;
        bit [31:0] erd;
        bit        gf;
        bit        ef;
        bit        w;
        bit [2:0]  s;
        bit [31:0] a;
        bit [31:0] dat;
        int        sel;

        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; strb[d] = 3'd0; addr[d] = 32'd0; wd[d] = 32'd0;
        end

        tab[0]  = '{1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 1'b0, 32'h00000000};
        tab[1]  = '{1'b0, 3'd2, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF};
        tab[2]  = '{1'b0, 3'd0, 32'h010, 32'h0,        1'b0, 32'hFFFFFFDE};
        tab[3]  = '{1'b0, 3'd4, 32'h013, 32'h0,        1'b0, 32'h000000EF};
        tab[4]  = '{1'b0, 3'd1, 32'h012, 32'h0,        1'b0, 32'hFFFFBEEF};
        tab[5]  = '{1'b0, 3'd5, 32'h010, 32'h0,        1'b0, 32'h0000DEAD};
        tab[6]  = '{1'b1, 3'd2, 32'h012, 32'h11111111, 1'b1, 32'h00000000};
        tab[7]  = '{1'b0, 3'd2, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF};
        tab[8]  = '{1'b1, 3'd2, 32'h000, 32'h01020304, 1'b0, 32'h00000000};
        tab[9]  = '{1'b0, 3'd2, 32'h400, 32'h0,        1'b1, 32'h00000000};
        tab[10] = '{1'b1, 3'd2, 32'h400, 32'hFFFFFFFF, 1'b1, 32'h00000000};
        tab[11] = '{1'b1, 3'd7, 32'h000, 32'hFFFFFFFF, 1'b1, 32'h00000000};
        tab[12] = '{1'b0, 3'd2, 32'h000, 32'h0,        1'b0, 32'h01020304};
        tab[13] = '{1'b0, 3'd1, 32'h011, 32'h0,        1'b1, 32'h00000000};
        tab[14] = '{1'b0, 3'd2, 32'h002, 32'h0,        1'b1, 32'h00000000};
        tab[15] = '{1'b0, 3'd3, 32'h000, 32'h0,        1'b1, 32'h00000000};
        tab[16] = '{1'b1, 3'd4, 32'h001, 32'h123456AA, 1'b0, 32'h00000000};
        tab[17] = '{1'b1, 3'd5, 32'h002, 32'h9876BBCC, 1'b0, 32'h00000000};
        tab[18] = '{1'b0, 3'd2, 32'h000, 32'h0,        1'b0, 32'h01AABBCC};
        tab[19] = '{1'b0, 3'd0, 32'h001, 32'h0,        1'b0, 32'hFFFFFFAA};
        tab[20] = '{1'b0, 3'd1, 32'h002, 32'h0,        1'b0, 32'hFFFFBBCC};
        tab[21] = '{1'b0, 3'd2, 32'hFFFFFFFC, 32'h0,   1'b1, 32'h00000000};

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_reset_ready", d), rdy[d], 1'b0);
            chk($sformatf("d%0d_reset_fault", d), flt[d], 1'b0);
            chk($sformatf("d%0d_reset_rdata", d), rd[d], 32'd0);
            chk($sformatf("d%0d_reset_busy", d), busy[d], 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Give every byte a defined value so later loads are predictable.
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < DEPTH / 4; k++) begin
                do_acc(d, 1'b1, 3'd2, 32'(k * 4), $urandom, grd, gf, erd, ef);
                chk($sformatf("d%0d_init_fault", d), gf, ef);
            end

        for (int i = 0; i < 22; i++) begin
            do_acc(0, tab[i].w, tab[i].s, tab[i].a, tab[i].wdat, grd, gf, erd, ef);
            chk($sformatf("tab%0d_fault", i), gf, tab[i].f);
            chk($sformatf("tab%0d_rdata", i), grd, tab[i].rdat);
        end

        // Reset during WAIT of a store: outputs clear, store never lands.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; strb[0] = 3'd2; addr[0] = 32'h20; wd[0] = 32'h12345678;
        @(posedge clk); #1;
        req[0] = 1'b0;
        chk("rst_wait_busy", busy[0], 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ready", rdy[0], 1'b0);
        chk("rst_mid_fault", flt[0], 1'b0);
        chk("rst_mid_rdata", rd[0], 32'd0);
        chk("rst_mid_busy", busy[0], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_late_ready", rdy[0], 1'b0);
        do_acc(0, 1'b0, 3'd2, 32'h20, 32'h0, grd, gf, erd, ef);
        chk("rst_old_contents", grd, erd);
        chk("rst_old_fault", gf, 1'b0);

        // Instance 1: ReqM held high, only every second request is taken.
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            req[1] = 1'b1; we[1] = 1'b1; strb[1] = 3'd2;
            addr[1] = 32'(32'h40 + 4 * j); wd[1] = $urandom;
            if (j % 2 == 0) model_step(1, 1'b1, 3'd2, addr[1], wd[1], ef, erd);
            @(posedge clk); #1;
            chk($sformatf("hold%0d_busy", j), busy[1], (j % 2 == 0) ? 1'b1 : 1'b0);
            chk($sformatf("hold%0d_ready", j), rdy[1], (j % 2 == 1) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        req[1] = 1'b0;
        for (int j = 0; j < 8; j++) begin
            do_acc(1, 1'b0, 3'd2, 32'(32'h40 + 4 * j), 32'h0, grd, gf, erd, ef);
            chk($sformatf("hold_rb%0d", j), grd, erd);
        end

        // Instance 1: word store straddling the top of memory wraps to address 0.
        do_acc(1, 1'b1, 3'd2, 32'h3FE, 32'hA1B2C3D4, grd, gf, erd, ef);
        chk("wrap_sw_fault", gf, 1'b0);
        do_acc(1, 1'b0, 3'd2, 32'h3FE, 32'h0, grd, gf, erd, ef);
        chk("wrap_lw", grd, 32'hA1B2C3D4);
        do_acc(1, 1'b0, 3'd4, 32'h000, 32'h0, grd, gf, erd, ef);
        chk("wrap_lbu_000", grd, 32'h000000C3);
        do_acc(1, 1'b0, 3'd4, 32'h001, 32'h0, grd, gf, erd, ef);
        chk("wrap_lbu_001", grd, 32'h000000D4);
        do_acc(1, 1'b0, 3'd4, 32'h3FF, 32'h0, grd, gf, erd, ef);
        chk("wrap_lbu_3ff", grd, 32'h000000B2);
        do_acc(1, 1'b0, 3'd1, 32'h3FF, 32'h0, grd, gf, erd, ef);
        chk("wrap_lh_3ff", grd, 32'hFFFFB2C3);
        chk("wrap_lh_fault", gf, 1'b0);

        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 300; k++) begin
                w = 1'($urandom);
                sel = int'($urandom_range(0, 15));
                if (sel < 13) begin
                    case (sel % 5)
                        0: s = 3'd0;
                        1: s = 3'd1;
                        2: s = 3'd2;
                        3: s = 3'd4;
                        default: s = 3'd5;
                    endcase
                end else begin
                    s = (sel == 13) ? 3'd3 : (sel == 14) ? 3'd6 : 3'd7;
                end
                if ($urandom_range(0, 7) == 0) a = 32'(DEPTH) + $urandom_range(0, 63);
                else a = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
                dat = $urandom;
                do_acc(d, w, s, a, dat, grd, gf, erd, ef);
                chk($sformatf("rnd_d%0d_%0d_fault", d, k), gf, ef);
                chk($sformatf("rnd_d%0d_%0d_rdata", d, k), grd, erd);
            end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
